// File: rtl/common_types_pkg.sv
// common_types_pkg: shared types and helpers for the memory request arbiter.
//   word_t       32-bit bus word
//   arb_state_t  arbiter FSM states
//   arb_client_t granted client (fetch or data)
//   DWRITE_*     data write size encoding, shared by d_wen and m_dwrite
package common_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP} arb_state_t;
    typedef enum logic {CLIENT_I, CLIENT_D} arb_client_t;
    localparam logic [1:0] DWRITE_BYTE = 2'b01;
    localparam logic [1:0] DWRITE_HALF = 2'b10;
    localparam logic [1:0] DWRITE_WORD = 2'b11;
    function automatic logic is_dwrite(input logic [1:0] w);
        return w == DWRITE_BYTE || w == DWRITE_HALF || w == DWRITE_WORD;
    endfunction
endpackage

// File: rtl/arb_priority_sel.sv
// arb_priority_sel: data-biased grant with fetch starvation guard.
//   clk, nrst        clock, synchronous active-low reset
//   en               arbitration allowed this cycle (arbiter idle)
//   i_req, d_req     pending requests from fetch and data clients
//   grant_i, grant_d one-hot grant, combinational, only while en
module arb_priority_sel #(
    parameter int MAX_D_STREAK = 4
) (
    input  logic clk,
    input  logic nrst,
    input  logic en,
    input  logic i_req,
    input  logic d_req,
    output logic grant_i,
    output logic grant_d
);
    localparam int SW = $clog2(MAX_D_STREAK + 1);
    logic [SW-1:0] streak_q, streak_d;
    logic force_i;
    assign force_i = streak_q == SW'(MAX_D_STREAK);
    assign grant_i = en && i_req && (!d_req || force_i);
    assign grant_d = en && d_req && !(i_req && force_i);
    // Streak only counts D grants that overtook a waiting fetch.
    always_comb
        streak_d = grant_i ? '0 :
                   grant_d ? (i_req ? (force_i ? streak_q : streak_q + 1'b1) : '0) : streak_q;
    always_ff @(posedge clk)
        streak_q <= !nrst ? '0 : streak_d;
endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: one-outstanding-transfer arbiter between fetch and data clients
// in front of the AHB-Lite bus master.
//   clk, nrst                 clock, synchronous active-low reset
//   i_req/i_addr -> i_ack/i_rdata                         fetch client handshake
//   d_ren/d_wen/d_addr/d_wdata -> d_ack/d_rdata/d_err     data client handshake
//   m_iread/m_dread/m_dwrite/m_iaddr/m_daddr/m_dstore     request to master
//   m_ihit/m_dhit/m_iload/m_dload                         completion from master
// Optional: define ARB_TIMEOUT_EN to abort a WAIT after TIMEOUT_CYCLES with d_err=1.
module mem_req_arbiter
    import common_types_pkg::*;
#(
    parameter int MAX_D_STREAK   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_ren,
    input  logic [1:0]  d_wen,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        m_iread,
    output logic        m_dread,
    output logic [1:0]  m_dwrite,
    output logic [31:0] m_iaddr,
    output logic [31:0] m_daddr,
    output logic [31:0] m_dstore,
    input  logic        m_ihit,
    input  logic        m_dhit,
    input  logic [31:0] m_iload,
    input  logic [31:0] m_dload
);
    arb_state_t  state_q, state_d;
    arb_client_t client_q, client_d;
    logic [1:0]  wr_q, wr_d;
    word_t       addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic        stale_q, stale_d;
    logic        d_req, grant_i, grant_d, hit, hit_ok, timed_out;

    assign d_req  = d_ren | is_dwrite(d_wen);
    assign hit    = (client_q == CLIENT_I) ? m_ihit : m_dhit;
    // A hit already high during ISSUE belongs to the previous transfer.
    assign hit_ok = hit && !stale_q;

    arb_priority_sel #(.MAX_D_STREAK(MAX_D_STREAK)) u_sel (
        .clk     (clk),
        .nrst    (nrst),
        .en      (state_q == ARB_IDLE),
        .i_req   (i_req),
        .d_req   (d_req),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
    assign timed_out = (state_q == ARB_WAIT) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    always_comb begin
        tmo_d = (state_q == ARB_WAIT) ? tmo_q + 1'b1 : '0;
        err_d = (state_q == ARB_WAIT) ? !hit_ok : (state_q == ARB_RESP) && err_q;
    end
    always_ff @(posedge clk) begin
        tmo_q <= !nrst ? '0 : tmo_d;
        err_q <= nrst && err_d;
    end
    assign d_err = (i_ack | d_ack) & err_q;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
    assign timed_out      = 1'b0;
    assign d_err          = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        client_d = client_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        stale_d  = stale_q;
        case (state_q)
            ARB_IDLE: if (grant_i | grant_d) begin
                state_d  = ARB_ISSUE;
                client_d = grant_i ? CLIENT_I : CLIENT_D;
                // A simultaneous read and write is served as the read.
                wr_d     = (grant_d && !d_ren) ? d_wen : 2'b00;
                addr_d   = grant_i ? i_addr : d_addr;
                wdata_d  = (grant_d && !d_ren) ? d_wdata : '0;
                rdata_d  = '0;
            end
            ARB_ISSUE: begin
                state_d = ARB_WAIT;
                stale_d = hit;
            end
            ARB_WAIT: begin
                stale_d = 1'b0;
                if (hit_ok | timed_out) begin
                    state_d = ARB_RESP;
                    rdata_d = (hit_ok && wr_q == 2'b00) ? ((client_q == CLIENT_I) ? m_iload : m_dload) : '0;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q  <= ARB_IDLE;
            client_q <= CLIENT_I;
            wr_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            stale_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            client_q <= client_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            stale_q  <= stale_d;
        end
    end

    assign m_iread  = state_q == ARB_ISSUE && client_q == CLIENT_I;
    assign m_dread  = state_q == ARB_ISSUE && client_q == CLIENT_D && wr_q == 2'b00;
    assign m_dwrite = (state_q == ARB_ISSUE && client_q == CLIENT_D) ? wr_q : 2'b00;
    assign m_iaddr  = (client_q == CLIENT_I) ? addr_q : '0;
    assign m_daddr  = (client_q == CLIENT_D) ? addr_q : '0;
    assign m_dstore = wdata_q;
    assign i_ack    = state_q == ARB_RESP && client_q == CLIENT_I;
    assign d_ack    = state_q == ARB_RESP && client_q == CLIENT_D;
    assign i_rdata  = i_ack ? rdata_q : '0;
    assign d_rdata  = d_ack ? rdata_q : '0;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: self-checking bench with a behavioural slave and grant-order model.
module tb_mem_req_arbiter;
    localparam int MAXS = 4;
    localparam int TO   = 255;

    logic        clk = 1'b0, nrst = 1'b0;
    logic        i_req = 1'b0, d_ren = 1'b0;
    logic [1:0]  d_wen = 2'b00;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic        m_ihit = 1'b0, m_dhit = 1'b0;
    logic [31:0] m_iload = '0, m_dload = '0;
    logic        i_ack, d_ack, d_err, m_iread, m_dread;
    logic [1:0]  m_dwrite;
    logic [31:0] i_rdata, d_rdata, m_iaddr, m_daddr, m_dstore;

    mem_req_arbiter #(.MAX_D_STREAK(MAXS), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .nrst(nrst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .m_iread(m_iread), .m_dread(m_dread), .m_dwrite(m_dwrite),
        .m_iaddr(m_iaddr), .m_daddr(m_daddr), .m_dstore(m_dstore),
        .m_ihit(m_ihit), .m_dhit(m_dhit), .m_iload(m_iload), .m_dload(m_dload)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0, cyc = 0;
    // Slave model: answers each issued request after s_lat WAIT cycles (never if s_lat < 0).
    logic        s_pend = 1'b0, s_pend_i = 1'b0, s_fix_en = 1'b0;
    logic [31:0] s_load = '0, s_fix = '0;
    int          s_cnt = 0, s_lat = 0, hit_cyc = -1, n_strobes = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        m_ihit  = 1'b0;
        m_dhit  = 1'b0;
        m_iload = $urandom;
        m_dload = $urandom;
        if (s_pend) begin
            if (s_cnt == 0) begin
                s_load = s_fix_en ? s_fix : $urandom;
                if (s_pend_i) begin m_ihit = 1'b1; m_iload = s_load; end
                else begin m_dhit = 1'b1; m_dload = s_load; end
                hit_cyc = cyc;
                s_pend  = 1'b0;
            end else s_cnt--;
        end
        if (m_iread || m_dread || m_dwrite != 2'b00) begin
            n_strobes++;
            s_pend   = s_lat >= 0;
            s_pend_i = m_iread;
            s_cnt    = s_lat;
        end
    endtask

    task automatic wait_ack(input int limit, output bit got);
        got = 1'b0;
        for (int k = 0; k < limit && !got; k++) begin
            tick();
            got = i_ack | d_ack;
        end
    endtask

    task automatic do_reset();
        nrst = 1'b0; i_req = 1'b0; d_ren = 1'b0; d_wen = 2'b00; s_pend = 1'b0; s_lat = 0;
        tick();
        tick();
        nrst = 1'b1;
    endtask

    task automatic test_reset();
        nrst = 1'b0; i_req = 1'b1; d_ren = 1'b1; d_wen = 2'b11;
        i_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
        tick();
        tick();
        checks++;
        if ({i_ack, d_ack, d_err, m_iread, m_dread, m_dwrite} !== 7'h0) begin
            errors++; $display("FAIL reset_ctrl: got %b want 0", {i_ack, d_ack, d_err, m_iread, m_dread, m_dwrite});
        end
        checks++;
        if ({i_rdata, d_rdata} !== 64'h0) begin
            errors++; $display("FAIL reset_rdata: got %h want 0", {i_rdata, d_rdata});
        end
        checks++;
        if ({m_iaddr, m_daddr, m_dstore} !== 96'h0) begin
            errors++; $display("FAIL reset_maddr: got %h want 0", {m_iaddr, m_daddr, m_dstore});
        end
        i_req = 1'b0; d_ren = 1'b0; d_wen = 2'b00; nrst = 1'b1;
    endtask

    task automatic test_lone_fetch();
        i_addr = 32'h0000_0100; i_req = 1'b1; s_lat = 0; s_fix_en = 1'b1; s_fix = 32'h0000_0013;
        tick();
        checks++;
        if ({m_iread, m_dread, m_dwrite} !== 4'b1000) begin
            errors++; $display("FAIL fetch_strobe: got %b want 1000", {m_iread, m_dread, m_dwrite});
        end
        checks++;
        if (m_iaddr !== 32'h100) begin
            errors++; $display("FAIL fetch_addr: got %h want 00000100", m_iaddr);
        end
        tick();
        checks++;
        if ({m_iread, i_ack} !== 2'b00) begin
            errors++; $display("FAIL fetch_wait: got iread,ack=%b want 00", {m_iread, i_ack});
        end
        tick();
        checks++;
        if ({i_ack, d_ack} !== 2'b10) begin
            errors++; $display("FAIL fetch_ack: got i,d=%b want 10", {i_ack, d_ack});
        end
        checks++;
        if (i_rdata !== 32'h13) begin
            errors++; $display("FAIL fetch_rdata: got %h want 00000013", i_rdata);
        end
        i_req = 1'b0; s_fix_en = 1'b0;
        tick();
        checks++;
        if (i_ack !== 1'b0) begin
            errors++; $display("FAIL fetch_ack_pulse: got %b want 0", i_ack);
        end
    endtask

    task automatic test_write();
        bit got;
        d_wen = 2'b01; d_addr = 32'h2000_0003; d_wdata = 32'h0000_00AB; s_lat = $urandom_range(0, 3);
        tick();
        checks++;
        if ({m_iread, m_dread, m_dwrite} !== 4'b0001) begin
            errors++; $display("FAIL write_strobe: got %b want 0001", {m_iread, m_dread, m_dwrite});
        end
        checks++;
        if ({m_daddr, m_dstore} !== {32'h2000_0003, 32'h0000_00AB}) begin
            errors++; $display("FAIL write_addr_data: got %h want 20000003000000ab", {m_daddr, m_dstore});
        end
        wait_ack(20, got);
        checks++;
        if ({got, i_ack, d_ack} !== 3'b101) begin
            errors++; $display("FAIL write_ack: got got,i,d=%b want 101", {got, i_ack, d_ack});
        end
        checks++;
        if (d_rdata !== 32'h0) begin
            errors++; $display("FAIL write_rdata: got %h want 0", d_rdata);
        end
        d_wen = 2'b00;
        tick();
    endtask

    task automatic test_wait_states();
        bit got;
        d_ren = 1'b1; d_addr = $urandom; s_lat = 5; n_strobes = 0;
        wait_ack(30, got);
        checks++;
        if ({got, d_ack} !== 2'b11) begin
            errors++; $display("FAIL ws_ack: got got,d_ack=%b want 11", {got, d_ack});
        end
        checks++;
        if (cyc !== hit_cyc + 1) begin
            errors++; $display("FAIL ws_ack_latency: got cycle %0d want %0d", cyc, hit_cyc + 1);
        end
        checks++;
        if (d_rdata !== s_load) begin
            errors++; $display("FAIL ws_rdata: got %h want %h", d_rdata, s_load);
        end
        d_ren = 1'b0;
        repeat (10) tick();
        checks++;
        if (n_strobes !== 1) begin
            errors++; $display("FAIL ws_single_issue: got %0d strobes want 1", n_strobes);
        end
    endtask

    task automatic test_reset_mid();
        bit got;
        int n_acks = 0;
        d_ren = 1'b1; d_addr = $urandom; s_lat = 20;
        repeat (4) tick();
        nrst = 1'b0; d_ren = 1'b0;
        tick();
        s_pend = 1'b0;
        checks++;
        if ({i_ack, d_ack, d_err, m_iread, m_dread, m_dwrite, i_rdata, d_rdata} !== 71'h0) begin
            errors++; $display("FAIL midreset_outputs: got %h want 0",
                               {i_ack, d_ack, d_err, m_iread, m_dread, m_dwrite, i_rdata, d_rdata});
        end
        nrst = 1'b1;
        repeat (10) begin
            tick();
            if (i_ack | d_ack) n_acks++;
        end
        checks++;
        if (n_acks !== 0) begin
            errors++; $display("FAIL midreset_no_ack: got %0d acks want 0", n_acks);
        end
        i_req = 1'b1; i_addr = $urandom; s_lat = 1;
        wait_ack(20, got);
        checks++;
        if ({got, i_ack, i_rdata} !== {2'b11, s_load}) begin
            errors++; $display("FAIL midreset_recover: got ack=%b rdata=%h want ack=11 rdata=%h",
                               {got, i_ack}, i_rdata, s_load);
        end
        i_req = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        bit got;
        int iss;
        d_ren = 1'b1; d_addr = $urandom; s_lat = -1;
        tick();
        iss = cyc;
`ifdef ARB_TIMEOUT_EN
        wait_ack(TO + 20, got);
        checks++;
        if ({got, d_ack, d_err, d_rdata} !== {3'b111, 32'h0}) begin
            errors++; $display("FAIL timeout_ack: got ack=%b err=%b rdata=%h want 1,1,1,0",
                               {got, d_ack}, d_err, d_rdata);
        end
        checks++;
        if (cyc !== iss + TO + 1) begin
            errors++; $display("FAIL timeout_cycle: got %0d want %0d", cyc, iss + TO + 1);
        end
        d_ren = 1'b0;
        tick();
`else
        wait_ack(TO + 40, got);
        checks++;
        if (got !== 1'b0) begin
            errors++; $display("FAIL no_timeout_hold: got ack after %0d cycles want none", cyc - iss);
        end
        do_reset();
`endif
    endtask

    task automatic test_arbitration();
        int streak = 0;
        bit ip = 1'b0, dp = 1'b0, got, exp_i, wr;
        logic [3:0]  exp_strobe;
        logic [31:0] exp_addr, exp_data;
        logic [9:0]  seq = '0;
        do_reset();
        for (int r = 0; r < 50; r++) begin
            bit ni, nd;
            ni = !ip && (r < 10 || $urandom_range(0, 1) == 1);
            nd = !dp && (r < 10 || $urandom_range(0, 1) == 1);
            if (!ip && !dp && !ni && !nd) nd = 1'b1;
            if (ni) begin ip = 1'b1; i_req = 1'b1; i_addr = $urandom; end
            if (nd) begin
                dp = 1'b1; d_ren = 1'($urandom_range(0, 1)); d_wen = 2'($urandom_range(0, 3));
                if (!d_ren && d_wen == 2'b00) d_ren = 1'b1;
                d_addr = $urandom; d_wdata = $urandom;
            end
            exp_i  = ip && (!dp || streak == MAXS);
            streak = exp_i ? 0 : (ip ? ((streak < MAXS) ? streak + 1 : MAXS) : 0);
            wr     = !exp_i && !d_ren;
            exp_strobe = exp_i ? 4'b1000 : (d_ren ? 4'b0100 : {2'b00, d_wen});
            exp_addr   = exp_i ? i_addr : d_addr;
            s_lat = $urandom_range(0, 3);
            tick();
            if (r < 10) seq[r] = m_iread;
            checks++;
            if ({m_iread, m_dread, m_dwrite} !== exp_strobe || (exp_i ? m_iaddr : m_daddr) !== exp_addr ||
                (wr && m_dstore !== d_wdata)) begin
                errors++; $display("FAIL arb_issue r%0d: got strobe=%b addr=%h want strobe=%b addr=%h",
                                   r, {m_iread, m_dread, m_dwrite}, exp_i ? m_iaddr : m_daddr, exp_strobe, exp_addr);
            end
            wait_ack(20, got);
            checks++;
            if ({got, i_ack, d_ack, d_err} !== {1'b1, exp_i, !exp_i, 1'b0}) begin
                errors++; $display("FAIL arb_ack r%0d: got got,i,d,err=%b want %b",
                                   r, {got, i_ack, d_ack, d_err}, {1'b1, exp_i, !exp_i, 1'b0});
            end
            exp_data = wr ? 32'h0 : s_load;
            checks++;
            if ((exp_i ? i_rdata : d_rdata) !== exp_data) begin
                errors++; $display("FAIL arb_rdata r%0d: got %h want %h", r, exp_i ? i_rdata : d_rdata, exp_data);
            end
            if (exp_i) begin ip = 1'b0; i_req = 1'b0; end
            else begin dp = 1'b0; d_ren = 1'b0; d_wen = 2'b00; end
            tick();
        end
        checks++;
        if (seq !== 10'b10_0001_0000) begin
            errors++; $display("FAIL arb_order: got I-grant mask %b want 1000010000", seq);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lone_fetch();
        test_write();
        test_wait_states();
        test_reset_mid();
        test_timeout();
        test_arbitration();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
